// File: rtl/pending_event_server.sv
`default_nettype none
// ============================================================================
// Module      : pending_event_server
// Description : Sticky per-source event flags with a round-robin server that
//               hands out pending source indices over a valid/ready handshake
//               and clears each flag as it is consumed. Lost events are
//               recorded in sticky overflow bits.
// Revision    : 1.0 - initial release
// ============================================================================
module pending_event_server #(
    parameter int NUM_INPUTS = 8,
    parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] event_in,
    output logic [NUM_INPUTS-1:0] pending,
    output logic                  any_pending,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      out_idx,
    output logic [NUM_INPUTS-1:0] overflow,
    input  logic                  clear_overflow
);

    localparam logic [0:0]       c_idle  = 1'b0;
    localparam logic [0:0]       c_offer = 1'b1;
    localparam logic [IDX_W:0]   c_num   = (IDX_W+1)'(NUM_INPUTS);
    localparam logic [IDX_W-1:0] c_last  = IDX_W'(NUM_INPUTS - 1);

    logic [0:0]            r_state;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_INPUTS-1:0] r_pending;
    logic [NUM_INPUTS-1:0] r_overflow;

    logic                  w_hs;
    logic [NUM_INPUTS-1:0] w_clr;
    logic [NUM_INPUTS-1:0] w_ovf_set;
    logic [IDX_W-1:0]      w_sel;
    logic [IDX_W:0]        w_cand;

    assign w_hs = (r_state == c_offer) && out_ready;

    // One-hot clear of the flag whose index is being accepted this cycle
    generate
        for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_clr
            assign w_clr[i] = w_hs && (r_idx == IDX_W'(i));
        end
    endgenerate

    // An event is lost only if its flag is already set and not being consumed
    assign w_ovf_set = event_in & r_pending & ~w_clr;

    // Round-robin search starting at r_ptr; the wrap is modulo NUM_INPUTS, so
    // non-power-of-two source counts never probe unused indices. Scanning
    // offsets from the far end lets the nearest hit overwrite earlier ones.
    always_comb begin
        w_sel  = '0;
        w_cand = '0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_cand >= c_num) begin
                w_cand = w_cand - c_num;
            end
            if (r_pending[w_cand[IDX_W-1:0]]) begin
                w_sel = w_cand[IDX_W-1:0];
            end
        end
    end

    // Server FSM: latch a selection in IDLE, hold it stable in OFFER until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (|r_pending) begin
                        r_idx   <= w_sel;
                        r_state <= c_offer;
                    end
                end
                c_offer: begin
                    if (out_ready) begin
                        r_ptr   <= (r_idx == c_last) ? '0 : r_idx + IDX_W'(1);
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // Sticky flags: a new event beats a same-cycle consume; overflow set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= '0;
            r_overflow <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_clr) | event_in;
            r_overflow <= (clear_overflow ? '0 : r_overflow) | w_ovf_set;
        end
    end

    assign pending     = r_pending;
    assign any_pending = |r_pending;
    assign out_valid   = (r_state == c_offer);
    assign out_idx     = r_idx;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: doc/pending_event_server.md
# pending_event_server

Sticky event collector and round-robin server: the read-side counterpart of the N-to-1 OR reducer. The OR summary only says that some source fired. This block also latches which sources fired, serves their indices one at a time over a valid/ready handshake, and clears each flag as it is consumed. It sits in the destination clock domain, after the per-bit synchronizers. All inputs are synchronous to `clk`.

## Interface
- `NUM_INPUTS`, default 8: number of event sources; legal range is 1 and up.
- `IDX_W`, default `$clog2(NUM_INPUTS)`, minimum 1: width of `out_idx`.

- `clk`  in  1: clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `event_in`  in  NUM_INPUTS: event pulses or levels; any cycle with bit i high is one event on source i.
- `pending`  out  NUM_INPUTS: sticky per-source flags (registered).
- `any_pending`  out  1: OR of `pending`, combinational from the register only.
- `out_valid`  out  1: `out_idx` is being offered.
- `out_ready`  in  1: consumer accepts the offered index.
- `out_idx`  out  IDX_W: index of the source being served.
- `overflow`  out  NUM_INPUTS: sticky; an event was lost on source i.
- `clear_overflow`  in  1: clears all `overflow` bits.

## Operation
- **Handshake:** a handshake occurs in any cycle where `out_valid` and `out_ready` are both high.
- **Pending bits:** `pending[i]` sets on `event_in[i]`. It clears on a handshake with `out_idx == i`. If the set and the clear happen in the same cycle, the set wins: `pending[i]` stays 1 and `overflow[i]` is not set.
- **Overflow set:** `overflow[i]` sets when `event_in[i]` is high, `pending[i]` is already 1, and this cycle is not a handshake clearing i.
- **Overflow clear:** `clear_overflow` zeroes `overflow`; a simultaneous set wins.
- **Selection:** the round-robin pointer `ptr` ranges 0..NUM_INPUTS-1. The search starts at `ptr` and wraps modulo NUM_INPUTS, not modulo 2^IDX_W. The first set `pending` bit is selected.
- **FSM: IDLE**
  - `out_valid` = 0.
  - If `pending` is nonzero: latch the selected index into `out_idx` and go to OFFER.
  - Otherwise stay in IDLE.
- **FSM: OFFER**
  - `out_valid` = 1.
  - `out_idx` and `out_valid` stay stable while `out_ready` is 0. New events never change the offered index.
  - On a handshake: `ptr` becomes `out_idx + 1`, wrapping from NUM_INPUTS-1 to 0. Then go to IDLE.
- **Idle index:** `out_idx` holds its last value while in IDLE.
- **NUM_INPUTS == 1:** `out_idx` is always 0 and `ptr` is always 0.
- **Reset:** while `rst` is high, all of the following are forced immediately, independent of `clk`:
  - `pending` = 0, `overflow` = 0, `any_pending` = 0.
  - `out_valid` = 0, `out_idx` = 0.
  - `ptr` = 0, state = IDLE.
- **Reset mid-offer:** an offered index is dropped without a handshake, and its event is lost.

## Timing
- **Event to pending:** `event_in[i]` sampled at edge t gives `pending[i]` = 1 and `any_pending` = 1 after edge t.
- **Pending to offer:** the FSM samples `pending` at edge t+1, so `out_valid` = 1 after edge t+1. Event-to-offer latency is 2 cycles.
- **Handshake at edge h:**
  - The `pending` bit clears after h.
  - `out_valid` is 0 after h, because the FSM is back in IDLE.
  - The next offer is valid after h+1.
- **Throughput:** one index every 2 cycles when `out_ready` is held high.
- **`any_pending`:** falls in the cycle after the handshake of the last pending bit, if no new event arrives.
- **Combinational paths:** none from any input to any output.

## Test plan
All scenarios use NUM_INPUTS = 8.
1. **Basic event.** Release reset and check every output is 0. Pulse `event_in`=8'b00000001 for 1 cycle with `out_ready`=1 → `pending`=8'b00000001 one cycle later, `out_valid`=1 with `out_idx`=0 two cycles after the event, handshake, then `pending`=0, `any_pending`=0, `ptr`=1.
2. **Round-robin and wrap.** Pulse 8'b00101100 with `out_ready`=1 → `out_idx` sequence 2, 3, 5, spaced 2 cycles apart, leaving `ptr`=6. Then pulse 8'b00000101 → sequence 0, 2 (search wraps past 6 and 7).
3. **Backpressure.** With `out_ready`=0, pulse 8'b10000000 → `out_valid`=1 and `out_idx`=7 held for 10 cycles. Pulse bit 1 during the stall → `out_idx` stays 7. Set `out_ready`=1 → sequence 7 then 1, with `ptr` wrapping 7→0.
4. **Overflow and same-cycle set/clear.** With `out_ready`=0, pulse bit 4 twice → `overflow`=8'b00010000. Assert `clear_overflow` → `overflow`=0. Pulse bit 4 in the same cycle as the handshake of index 4 → `pending[4]` stays 1, `overflow` stays 0, and index 4 is served again.
5. **Asynchronous reset mid-offer.** While `out_valid`=1, `out_idx`=3 and `pending`=8'b01001000, assert `rst` between clock edges → `out_valid`, `pending`, `any_pending` and `overflow` all go to 0 before the next edge. After release, the first event on bit 6 is served with `ptr` starting at 0.
6. **All sources at once.** Pulse 8'hFF with `out_ready`=1 → indices 0 through 7 in order over 16 cycles, and `any_pending` falls one cycle after the handshake of index 7.
